// File: rtl/sram_pkg.sv
`default_nettype none
// Shared state encoding and width defaults for the SRAM request controller.
package sram_pkg;

  localparam int ADDR_W_DEF = 18;
  localparam int DATA_W_DEF = 16;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/sram_req_ctrl.sv
`default_nettype none
// Single-port asynchronous SRAM bus controller: one request per
// IDLE/SETUP/ACCESS/HOLD bus cycle, all pad-side strobes registered.
module sram_req_ctrl
  import sram_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iREQ_VALID,
  output logic              oREQ_READY,
  input  logic              iREQ_WE,
  input  logic [ADDR_W-1:0] iREQ_ADDR,
  input  logic [DATA_W-1:0] iREQ_DATA,
  input  logic [1:0]        iREQ_BE,
  output logic [DATA_W-1:0] oRD_DATA,
  output logic              oRD_VALID,
  output logic              oBUSY,
  output logic [ADDR_W-1:0] oSRAM_ADDR,
  output logic [DATA_W-1:0] oSRAM_DATA,
  output logic              oSRAM_WE_N,
  output logic              oSRAM_OE_N,
  output logic              oSRAM_CE_N,
  output logic              oSRAM_UB_N,
  output logic              oSRAM_LB_N,
  input  logic [DATA_W-1:0] iSRAM_DATA
);

  localparam int               HALF   = DATA_W / 2;
  localparam logic [CNT_W-1:0] C_WAIT = CNT_W'(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [1:0]        be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              ce_n_q, ce_n_d;
  logic              we_n_q, we_n_d;
  logic              oe_n_q, oe_n_d;
  logic              ub_n_q, ub_n_d;
  logic              lb_n_q, lb_n_d;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      be_q     <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ce_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      ub_n_q   <= 1'b1;
      lb_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      ce_n_q   <= ce_n_d;
      we_n_q   <= we_n_d;
      oe_n_q   <= oe_n_d;
      ub_n_q   <= ub_n_d;
      lb_n_q   <= lb_n_d;
    end
  end

  // Strobe flops are loaded with the value for the state being entered,
  // so every pad output changes exactly on the state-transition edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    be_d     = be_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    ce_n_d   = ce_n_q;
    we_n_d   = we_n_q;
    oe_n_d   = oe_n_q;
    ub_n_d   = ub_n_q;
    lb_n_d   = lb_n_q;

    case (state_q)
      ST_IDLE: begin
        if (iREQ_VALID) begin
          state_d = ST_SETUP;
          we_d    = iREQ_WE;
          be_d    = iREQ_BE;
          addr_d  = iREQ_ADDR;
          wdata_d = iREQ_DATA;
          ce_n_d  = 1'b0;
          we_n_d  = 1'b1;
          oe_n_d  = iREQ_WE;
          ub_n_d  = ~iREQ_BE[1];
          lb_n_d  = ~iREQ_BE[0];
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        cnt_d   = C_WAIT;
        we_n_d  = ~we_q;
        oe_n_d  = we_q;
      end
      ST_ACCESS: begin
        if (cnt_q == 4'd1) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          we_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          if (!we_q) begin
            rdata_d  = {iSRAM_DATA[DATA_W-1:HALF] & {HALF{be_q[1]}},
                        iSRAM_DATA[HALF-1:0]      & {HALF{be_q[0]}}};
            rvalid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
        ce_n_d  = 1'b1;
        ub_n_d  = 1'b1;
        lb_n_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign oREQ_READY = (state_q == ST_IDLE);
  assign oBUSY      = (state_q != ST_IDLE);
  assign oRD_DATA   = rdata_q;
  assign oRD_VALID  = rvalid_q;
  assign oSRAM_ADDR = addr_q;
  assign oSRAM_DATA = wdata_q;
  assign oSRAM_CE_N = ce_n_q;
  assign oSRAM_WE_N = we_n_q;
  assign oSRAM_OE_N = oe_n_q;
  assign oSRAM_UB_N = ub_n_q;
  assign oSRAM_LB_N = lb_n_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_req_ctrl.sv
`default_nettype none
// Randomized bench for sram_req_ctrl: two instances (WAIT_CYCLES 1 and 4)
// checked cycle by cycle against a transaction-level reference model.
module tb_sram_req_ctrl;

  logic        clk;
  logic        rst_n     [2];
  logic        req_valid [2];
  logic        req_we    [2];
  logic [17:0] req_addr  [2];
  logic [15:0] req_data  [2];
  logic [1:0]  req_be    [2];
  logic        ready_o   [2];
  logic [15:0] rd_data   [2];
  logic        rd_valid  [2];
  logic        busy      [2];
  logic [17:0] s_addr    [2];
  logic [15:0] s_wdata   [2];
  logic [15:0] s_rdata   [2];
  logic        we_n      [2];
  logic        oe_n      [2];
  logic        ce_n      [2];
  logic        ub_n      [2];
  logic        lb_n      [2];

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] sram_mem [logic [17:0]];
  logic [15:0] ref_mem  [logic [17:0]];
  logic [15:0] last_rd  [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sram_req_ctrl #(.WAIT_CYCLES(g == 0 ? 1 : 4)) u_dut (
      .iCLK       (clk),
      .iRST_N     (rst_n[g]),
      .iREQ_VALID (req_valid[g]),
      .oREQ_READY (ready_o[g]),
      .iREQ_WE    (req_we[g]),
      .iREQ_ADDR  (req_addr[g]),
      .iREQ_DATA  (req_data[g]),
      .iREQ_BE    (req_be[g]),
      .oRD_DATA   (rd_data[g]),
      .oRD_VALID  (rd_valid[g]),
      .oBUSY      (busy[g]),
      .oSRAM_ADDR (s_addr[g]),
      .oSRAM_DATA (s_wdata[g]),
      .oSRAM_WE_N (we_n[g]),
      .oSRAM_OE_N (oe_n[g]),
      .oSRAM_CE_N (ce_n[g]),
      .oSRAM_UB_N (ub_n[g]),
      .oSRAM_LB_N (lb_n[g]),
      .iSRAM_DATA (s_rdata[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [15:0] mem_rd(input logic [17:0] a);
    return sram_mem.exists(a) ? sram_mem[a] : 16'h0000;
  endfunction

  function automatic logic [15:0] ref_rd(input logic [17:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
  endfunction

  // Pin-level SRAM: writes on the closing edge of a WE_N-low cycle,
  // read data valid only while OE_N is low (noise otherwise).
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!ce_n[d] && !we_n[d]) begin
        logic [15:0] w;
        w = mem_rd(s_addr[d]);
        if (!ub_n[d]) w[15:8] = s_wdata[d][15:8];
        if (!lb_n[d]) w[7:0]  = s_wdata[d][7:0];
        sram_mem[s_addr[d]] = w;
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++)
      s_rdata[d] = (!oe_n[d] && !ce_n[d]) ? mem_rd(s_addr[d]) : 16'($urandom);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] pins(input int d);
    return {ce_n[d], we_n[d], oe_n[d], ub_n[d], lb_n[d], rd_valid[d], ready_o[d], busy[d]};
  endfunction

  // One transaction; entered and left just after a falling edge.
  // Cycle k after the handshake: 1=setup, 2..W+1=access, W+2=hold, W+3=idle.
  task automatic do_txn(input int d, input bit we, input logic [17:0] addr,
                        input logic [15:0] data, input logic [1:0] be, input bit keep);
    int w;
    int waited;
    logic [15:0] exp_rd;
    logic [7:0]  exp_pins;
    w = (d == 0) ? 1 : 4;
    waited = 0;
    while (!ready_o[d] && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("ready_wait", ready_o[d], 1'b1);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_data[d]  = data;
    req_be[d]    = be;
    exp_rd = ref_rd(addr) & {{8{be[1]}}, {8{be[0]}}};
    if (we) begin
      logic [15:0] m;
      m = ref_rd(addr);
      if (be[1]) m[15:8] = data[15:8];
      if (be[0]) m[7:0]  = data[7:0];
      ref_mem[addr] = m;
    end
    for (int k = 1; k <= w + 3; k++) begin
      bit act;
      @(negedge clk);
      act = (k <= w + 2);
      exp_pins[7] = !act;
      exp_pins[6] = !(we && k >= 2 && k <= w + 1);
      exp_pins[5] = !(!we && k <= w + 1);
      exp_pins[4] = act ? ~be[1] : 1'b1;
      exp_pins[3] = act ? ~be[0] : 1'b1;
      exp_pins[2] = !we && (k == w + 2);
      exp_pins[1] = (k == w + 3);
      exp_pins[0] = (k != w + 3);
      chk($sformatf("pins{ce,we,oe,ub,lb,rv,rdy,busy} k=%0d", k), pins(d), exp_pins);
      if (act) begin
        chk("sram_addr", s_addr[d], addr);
        chk("sram_data", s_wdata[d], data);
      end
      if (k == w + 2 && !we) begin
        chk("rd_data", rd_data[d], exp_rd);
        last_rd[d] = exp_rd;
      end
      if (k == w + 3) begin
        chk("rd_hold", rd_data[d], last_rd[d]);
        if (we) chk("mem_write", mem_rd(addr), ref_rd(addr));
        req_valid[d] = keep;
      end else begin
        req_valid[d] = keep ? 1'b1 : 1'($urandom);
        req_we[d]    = 1'($urandom);
        req_addr[d]  = 18'($urandom);
        req_data[d]  = 16'($urandom);
        req_be[d]    = 2'($urandom);
      end
    end
  endtask

  // Reset pulse two cycles after the handshake (inside ACCESS).
  task automatic rst_mid(input int d, input bit we);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = 18'h00100;
    req_data[d]  = 16'($urandom);
    req_be[d]    = 2'b11;
    @(negedge clk);
    req_valid[d] = 1'b0;
    @(negedge clk);
    chk("pre_rst_ce", ce_n[d], 1'b0);
    #2 rst_n[d] = 1'b0;
    #1;
    chk("rst_pins", pins(d), 8'b11111010);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_rv", rd_valid[d], 1'b0);
    end
    rst_n[d] = 1'b1;
    last_rd[d] = 16'h0000;
    @(negedge clk);
    chk("post_rst_pins", pins(d), 8'b11111010);
    chk("post_rst_rd", rd_data[d], 16'h0000);
  endtask

  task automatic rand_txns(input int d, input int n);
    for (int i = 0; i < n; i++)
      do_txn(d, 1'($urandom), 18'($urandom_range(0, 31)), 16'($urandom), 2'($urandom), 1'b0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d]     = 1'b0;
      req_valid[d] = 1'b0;
      req_we[d]    = 1'b0;
      req_addr[d]  = '0;
      req_data[d]  = '0;
      req_be[d]    = '0;
      last_rd[d]   = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_pins", pins(d), 8'b11111010);
      chk("reset_addr", s_addr[d], 18'h0);
      chk("reset_wdata", s_wdata[d], 16'h0);
      chk("reset_rdata", rd_data[d], 16'h0);
    end
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);
    chk("ready_after_rst0", ready_o[0], 1'b1);
    chk("ready_after_rst1", ready_o[1], 1'b1);

    do_txn(0, 1'b1, 18'h00010, 16'hA5C3, 2'b11, 1'b0);
    do_txn(0, 1'b0, 18'h00010, 16'h0F0F, 2'b10, 1'b0);
    chk("read_A500", rd_data[0], 16'hA500);
    do_txn(0, 1'b1, 18'h3FFFF, 16'h1234, 2'b00, 1'b0);
    chk("be00_mem", mem_rd(18'h3FFFF), 16'h0000);
    do_txn(0, 1'b0, 18'h3FFFF, 16'h0000, 2'b11, 1'b0);
    rand_txns(0, 20);

    do_txn(1, 1'b1, 18'h00005, 16'hBEEF, 2'b11, 1'b0);
    for (int i = 0; i < 3; i++)
      do_txn(1, 1'b0, 18'(5 + i), 16'($urandom), 2'b11, 1'b1);
    do_txn(1, 1'b0, 18'h00005, 16'h0000, 2'b01, 1'b0);
    rand_txns(1, 15);

    rst_mid(1, 1'b1);
    rst_mid(1, 1'b0);
    rst_mid(0, 1'b1);
    rand_txns(0, 4);
    rand_txns(1, 4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
